// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Stage 1 registers operands, bit P/G and group P/G. Stage 2 resolves carries by two-level lookahead.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = (BLOCK >= 1) ? WIDTH / BLOCK : 1;

  generate
    if (BLOCK < 1) begin : g_bad_block
      $error("cla_pipe_adder: BLOCK must be at least 1");
    end else if ((WIDTH % BLOCK) != 0) begin : g_bad_width
      $error("cla_pipe_adder: WIDTH must be a multiple of BLOCK");
    end
  endgenerate

  logic             s1_valid_q;
  logic [WIDTH-1:0] a_q, b_q, p_q, g_q;
  logic             c0_q;
  logic [NG-1:0]    gp_q, gg_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  logic             s2_adv;

  assign s2_adv   = !out_valid_q | out_ready;
  assign in_ready = !s1_valid_q | s2_adv;

  // Stage 1: operand conditioning and generate/propagate
  logic [WIDTH-1:0] b_eff_d, p_d, g_d;
  logic             c0_d;
  logic [NG-1:0]    gp_d, gg_d;

  always_comb begin : p_stage1
    logic gg_t, gp_t;
    gg_t    = 1'b0;
    gp_t    = 1'b1;
    b_eff_d = sub ? ~b : b;
    c0_d    = cin ^ sub;
    p_d     = a ^ b_eff_d;
    g_d     = a & b_eff_d;
    gp_d    = '0;
    gg_d    = '0;
    for (int k = 0; k < NG; k++) begin
      gg_t = 1'b0;
      gp_t = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        gg_t = g_d[k*BLOCK+i] | (p_d[k*BLOCK+i] & gg_t);
        gp_t = gp_t & p_d[k*BLOCK+i];
      end
      gg_d[k] = gg_t;
      gp_d[k] = gp_t;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      p_q        <= '0;
      g_q        <= '0;
      c0_q       <= 1'b0;
      gp_q       <= '0;
      gg_q       <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        a_q  <= a;
        b_q  <= b_eff_d;
        p_q  <= p_d;
        g_q  <= g_d;
        c0_q <= c0_d;
        gp_q <= gp_d;
        gg_q <= gg_d;
      end
    end
  end

  // Stage 2: group carries flattened over group P/G, then bit carries inside each group
  logic [NG:0]      cg;
  logic [WIDTH:0]   cb;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d, ovf_d;

  always_comb begin : p_carry
    logic term;
    term = 1'b0;
    cg   = '0;
    cb   = '0;
    for (int k = 0; k <= NG; k++) begin
      term = c0_q;
      for (int m = 0; m < k; m++) term = term & gp_q[m];
      cg[k] = term;
      for (int j = 0; j < k; j++) begin
        term = gg_q[j];
        for (int m = j + 1; m < k; m++) term = term & gp_q[m];
        cg[k] = cg[k] | term;
      end
    end
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < BLOCK; i++) begin
        term = cg[k];
        for (int m = 0; m < i; m++) term = term & p_q[k*BLOCK+m];
        cb[k*BLOCK+i] = term;
        for (int j = 0; j < i; j++) begin
          term = g_q[k*BLOCK+j];
          for (int m = j + 1; m < i; m++) term = term & p_q[k*BLOCK+m];
          cb[k*BLOCK+i] = cb[k*BLOCK+i] | term;
        end
      end
    end
    cb[WIDTH] = cg[NG];
    sum_d     = a_q ^ b_q ^ cb[WIDTH-1:0];
    cout_d    = cb[WIDTH];
    ovf_d     = cb[WIDTH-1] ^ cb[WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      // Fields only move when a new result lands, so they hold across bubbles and stalls.
      if (s1_valid_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and streamed checks of cla_pipe_adder at 16/4 with a scoreboard,
// plus latency and wrap checks at 32/8.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  logic        in_valid32, in_ready32, cin32, sub32, out_valid32, out_ready32, cout32, ovf32;
  logic [31:0] a32, b32, sum32;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_emit = 0;
  logic [17:0] exp_q[$];

  cla_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  cla_pipe_adder #(.WIDTH(32), .BLOCK(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .cin(cin32), .sub(sub32), .out_valid(out_valid32),
    .out_ready(out_ready32), .sum(sum32), .cout(cout32), .ovf(ovf32)
  );

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  // Reference: {cout, ovf, sum}; overflow from operand/result signs.
  function automatic logic [17:0] model16(input logic [15:0] av, input logic [15:0] bv,
                                          input logic ci, input logic sb);
    logic [15:0] be;
    logic [16:0] r;
    logic        v;
    be = sb ? ~bv : bv;
    r  = {1'b0, av} + {1'b0, be} + {16'd0, ci ^ sb};
    v  = (av[15] == be[15]) && (r[15] != av[15]);
    return {r[16], v, r[15:0]};
  endfunction

  // One cycle on dut16: drive at negedge, then score outputs and predict the accept.
  task automatic step(input logic v, input logic [15:0] av, input logic [15:0] bv,
                      input logic ci, input logic sb, input logic ordy, output logic acc);
    @(negedge clk);
    in_valid  = v;
    a         = av;
    b         = bv;
    cin       = ci;
    sub       = sb;
    out_ready = ordy;
    #1;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 40'(out_valid), 40'(0));
      end else begin
        check("scoreboard", {cout, ovf, sum}, exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_emit++;
        end
      end
    end
    acc = in_valid & in_ready;
    if (acc) exp_q.push_back(model16(av, bv, ci, sb));
  endtask

  task automatic op16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                      input logic ci, input logic sb, input logic [17:0] expv);
    logic acc;
    step(1'b1, av, bv, ci, sb, 1'b1, acc);
    check({tag, "_acc"}, 40'(acc), 40'(1));
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, acc);
    check({tag, "_lat1"}, 40'(out_valid), 40'(0));
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, acc);
    check(tag, {out_valid, cout, ovf, sum}, {1'b1, expv});
  endtask

  task automatic op32(input string tag, input logic [31:0] av, input logic [31:0] bv,
                      input logic [33:0] expv);
    @(negedge clk);
    in_valid32 = 1'b1; a32 = av; b32 = bv; cin32 = 1'b0; sub32 = 1'b0; out_ready32 = 1'b1;
    #1;
    check({tag, "_rdy"}, 40'(in_ready32), 40'(1));
    @(negedge clk);
    in_valid32 = 1'b0;
    #1;
    check({tag, "_lat1"}, 40'(out_valid32), 40'(0));
    @(negedge clk);
    #1;
    check(tag, {out_valid32, cout32, ovf32, sum32}, {1'b1, expv});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   sent, cyc, emit0;
    in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 1;
    in_valid32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; out_ready32 = 1;

    #2;
    check("rst_out_valid", 40'(out_valid), 40'(0));
    check("rst_fields", {cout, ovf, sum}, 40'(0));
    check("rst_in_ready", 40'(in_ready), 40'(1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    op16("add_basic",   16'h000B, 16'h0006, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0011});
    op16("add_wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
    op16("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
    op16("sub_pos",     16'h0005, 16'h0003, 1'b0, 1'b1, {1'b1, 1'b0, 16'h0002});
    op16("sub_neg",     16'h0003, 16'h0005, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    op16("sub_borrow",  16'h0005, 16'h0003, 1'b1, 1'b1, {1'b1, 1'b0, 16'h0001});
    op16("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    op16("add_cin",     16'h00FF, 16'h0F00, 1'b1, 1'b0, {1'b0, 1'b0, 16'h1000});

    // Stall with out_ready low: two ops fit, the third is refused.
    emit0 = n_emit;
    step(1'b1, 16'h1111, 16'h0001, 1'b0, 1'b0, 1'b0, acc);
    check("stall_acc1", 40'(acc), 40'(1));
    step(1'b1, 16'h2222, 16'h0002, 1'b0, 1'b0, 1'b0, acc);
    check("stall_acc2", 40'(acc), 40'(1));
    step(1'b1, 16'h3333, 16'h0003, 1'b0, 1'b0, 1'b0, acc);
    check("stall_full_rdy", 40'(in_ready), 40'(0));
    step(1'b1, 16'h3333, 16'h0003, 1'b0, 1'b0, 1'b0, acc);
    check("stall_hold_rdy", 40'(in_ready), 40'(0));
    step(1'b1, 16'h3333, 16'h0003, 1'b0, 1'b0, 1'b1, acc);
    check("stall_release_rdy", 40'(in_ready), 40'(1));
    for (int i = 0; i < 4; i++) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, acc);
    check("stall_drained", 40'(n_emit - emit0), 40'(3));

    // Random stream with random bubbles and back-pressure.
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      step(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0), acc);
      if (acc) sent++;
      cyc++;
    end
    check("stream_sent", 40'(sent), 40'(1000));
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, acc);
      cyc++;
    end
    check("stream_drain", 40'(exp_q.size()), 40'(0));

    // Reset with two ops in flight.
    step(1'b1, 16'h1234, 16'h0101, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 16'h00F0, 16'h000F, 1'b0, 1'b0, 1'b0, acc);
    @(posedge clk);
    #2;
    check("pre_rst_valid", 40'(out_valid), 40'(1));
    check("pre_rst_rdy", 40'(in_ready), 40'(0));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 40'(out_valid), 40'(0));
    check("mid_rst_fields", {cout, ovf, sum}, 40'(0));
    exp_q.delete();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    op16("post_rst", 16'h000B, 16'h0006, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0011});

    op32("w32_basic", 32'h0000_000B, 32'h0000_0006, {1'b0, 1'b0, 32'h0000_0011});
    op32("w32_wrap",  32'hFFFF_FFFF, 32'h0000_0001, {1'b1, 1'b0, 32'h0000_0000});
    op32("w32_ovf",   32'h7FFF_FFFF, 32'h0000_0001, {1'b0, 1'b1, 32'h8000_0000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
